awg_mc: RTL and testbench
=========================

Name: awg_mc

Overview:
Multi-channel arbitrary waveform generator. Successor to the single-channel 12-bit/1024-sample AWG, generalised in sample width, memory depth and channel count. Each channel has its own sample RAM, prescaler, play length and mode: hold, direct passthrough, continuous loop, or triggered one-shot. It sits between the host register/load interface and the DAC output stage.

Parameters:
DW, 12, sample width in bits
AW, 10, address width; each channel RAM holds 2**AW samples
NCH, 2, number of channels (>=1)
PW, 4, prescaler width
CW is local, not a parameter: CW = max(1, clog2(NCH)).

Ports:
ck  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  sample RAM write strobe
wr_ch  in  CW  channel selected for write
wr_addr  in  AW  write address
wr_data  in  DW  write data
ch_mode  in  2*NCH  per channel: 00 hold, 01 direct, 10 loop, 11 one-shot
ch_pre  in  PW*NCH  per-channel prescaler; a value of 0 is treated as 1
ch_len  in  AW*NCH  per-channel last play address, inclusive
direct_in  in  DW*NCH  per-channel direct sample
trig  in  NCH  per-channel start/restart, level sampled on the clock edge
out  out  DW*NCH  per-channel sample
busy  out  NCH  channel in RUN
done  out  NCH  one-cycle pulse at one-shot completion
Channel c occupies bits [c*W +: W] of every packed bus.

Behaviour:
- Reset (async, rst_n=0): all out=0, busy=0, done=0, ptr=0, precnt=0, state=IDLE. RAM contents are not cleared and survive reset.
- RAM write: when wr_en=1, the edge writes mem[wr_ch][wr_addr] = wr_data.
  - Writes are legal in every state.
  - A same-cycle read of the written address returns the old data (read-before-write).
  - wr_ch >= NCH: the write is ignored.
- Per-channel FSM states: IDLE, RUN, DONE. Channels are fully independent.
- Mode 00 (hold): state goes to IDLE, ptr=0, out holds its last value, trig is ignored.
- Mode 01 (direct): state goes to IDLE, out <= direct_in every clock (1-cycle latency), trig is ignored.
- Start (mode 10/11): trig=1 at edge E0 in any state gives state=RUN, ptr=0, precnt=0.
  - Retrigger while in RUN restarts at address 0.
- RUN, each edge:
  - out <= mem[ptr], a synchronous read of the current ptr.
  - tick = (precnt >= P-1), where P = max(ch_pre,1).
  - On tick: precnt=0 and ptr advances; otherwise precnt+1.
  - Using >= means that lowering ch_pre mid-count ticks immediately.
  - Result: first sample mem[0] appears after E1; each sample is held for P clocks.
- Loop (10): on tick with ptr==ch_len, ptr wraps to 0. There is no gap cycle at the wrap.
- One-shot (11): on tick with ptr==ch_len, state goes to DONE and done=1 for exactly one cycle.
  - The same edge loads out=mem[ch_len]; out then holds.
  - busy falls at the same edge.
  - trig in DONE restarts the channel.
- Mode switch between 10 and 11 while in RUN: takes effect at the next ptr==ch_len tick.
- Mode switch to 00/01 in any state: takes effect at the next edge. busy falls; no done pulse.
- ch_len changed below the current ptr: ptr runs to 2**AW-1 and wraps to 0 (natural AW-bit wrap). In one-shot mode this wrap continues to the new ch_len before completing.
- ch_len = 0: a single sample is played and repeated (loop) or completed after P clocks (one-shot).
- busy = (state==RUN), registered.

Test Plan:
1. Write ch0 addr 0..7 = 0x100+i; ch_len0=7, pre=1, mode 10; pulse trig0 -> out0 = 0x100 one clock after the trig edge, then 0x101..0x107, then 0x100 again with no gap; busy0=1 throughout.
2. Same load with pre=3 -> each value is held 3 clocks. pre=0 -> identical to pre=1. Changing pre 15->1 mid-count advances on the next edge.
3. ch1 addr 0..3 = 0xA00..0xA03, ch_len1=3, mode 11, pre=2; trig1 -> out1 sequence 0xA00, 0xA00, 0xA01, 0xA01, 0xA02, 0xA02, 0xA03, 0xA03; done1 pulses exactly once; busy1=0 afterwards; out1 holds 0xA03. A second trig1 replays the sequence.
4. Mode 01 on ch0 with direct_in0=0x0AE -> out0=0x0AE one clock later. Switch to mode 00 -> out0 stays 0x0AE; trig0 is ignored.
5. Assert rst_n mid-loop -> out=0, busy=0 immediately. After release, trig0 replays the previously loaded 0x100.. data (RAM retained).
6. Both channels running while writing ch1 addr 2 = 0xFFF -> ch0 output is unaffected. ch1 shows 0xFFF on its next pass through addr 2. A write with wr_ch >= NCH changes nothing.

Source files
------------

// File: rtl/awg_mc_if.sv
// ============================================================================
//  Module   : awg_mc_if
//  Purpose  : Host sample-RAM write bus for the multi-channel AWG.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface awg_mc_if #(
    parameter int DW = 12,
    parameter int AW = 10,
    parameter int CW = 1
);
    logic          wr_en;
    logic [CW-1:0] wr_ch;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    modport master (output wr_en, output wr_ch, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_ch, input  wr_addr, input  wr_data);
endinterface

`default_nettype wire

// File: rtl/awg_mc.sv
// ============================================================================
//  Module   : awg_mc
//  Purpose  : Multi-channel arbitrary waveform generator (hold/direct/loop/one-shot).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module awg_mc #(
    parameter int DW  = 12,
    parameter int AW  = 10,
    parameter int NCH = 2,
    parameter int PW  = 4
) (
    input  wire logic              ck,
    input  wire logic              rst_n,
    awg_mc_if.slave                wr,
    input  wire logic [2*NCH-1:0]  ch_mode,
    input  wire logic [PW*NCH-1:0] ch_pre,
    input  wire logic [AW*NCH-1:0] ch_len,
    input  wire logic [DW*NCH-1:0] direct_in,
    input  wire logic [NCH-1:0]    trig,
    output logic      [DW*NCH-1:0] out,
    output logic      [NCH-1:0]    busy,
    output logic      [NCH-1:0]    done
);
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [DW-1:0] mem [DEPTH];

        state_t        state_q, state_d;
        logic [AW-1:0] ptr_q, ptr_d;
        logic [PW-1:0] precnt_q, precnt_d;
        logic [DW-1:0] out_q, out_d;
        logic          busy_q, busy_d;
        logic          done_q, done_d;

        logic [1:0]    mode;
        logic [PW-1:0] pre;
        logic [PW-1:0] pre_m1;
        logic [AW-1:0] len;
        logic          tick;

        assign mode   = ch_mode[2*c +: 2];
        assign pre    = ch_pre[PW*c +: PW];
        assign len    = ch_len[AW*c +: AW];
        // A prescaler of 0 behaves as 1, so the terminal count is 0 in both cases.
        assign pre_m1 = (pre == '0) ? '0 : pre - 1'b1;
        assign tick   = (precnt_q >= pre_m1);

        // Out-of-range channel numbers never match, so such writes fall away.
        always_ff @(posedge ck) begin
            if (wr.wr_en && (wr.wr_ch == CW'(c))) begin
                mem[wr.wr_addr] <= wr.wr_data;
            end
        end

        always_comb begin
            state_d  = state_q;
            ptr_d    = ptr_q;
            precnt_d = precnt_q;
            out_d    = out_q;
            done_d   = 1'b0;

            case (mode)
                2'b00: begin
                    state_d  = S_IDLE;
                    ptr_d    = '0;
                    precnt_d = '0;
                end
                2'b01: begin
                    state_d  = S_IDLE;
                    ptr_d    = '0;
                    precnt_d = '0;
                    out_d    = direct_in[DW*c +: DW];
                end
                default: begin
                    if (trig[c]) begin
                        state_d  = S_RUN;
                        ptr_d    = '0;
                        precnt_d = '0;
                    end else if (state_q == S_RUN) begin
                        out_d = mem[ptr_q];
                        if (tick) begin
                            precnt_d = '0;
                            if (ptr_q == len) begin
                                if (mode == 2'b11) begin
                                    state_d = S_DONE;
                                    done_d  = 1'b1;
                                end else begin
                                    ptr_d = '0;
                                end
                            end else begin
                                // Natural AW-bit wrap when len was lowered below ptr.
                                ptr_d = ptr_q + 1'b1;
                            end
                        end else begin
                            precnt_d = precnt_q + 1'b1;
                        end
                    end
                end
            endcase

            busy_d = (state_d == S_RUN);
        end

        always_ff @(posedge ck or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= S_IDLE;
                ptr_q    <= '0;
                precnt_q <= '0;
                out_q    <= '0;
                busy_q   <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                ptr_q    <= ptr_d;
                precnt_q <= precnt_d;
                out_q    <= out_d;
                busy_q   <= busy_d;
                done_q   <= done_d;
            end
        end

        assign out[DW*c +: DW] = out_q;
        assign busy[c]         = busy_q;
        assign done[c]         = done_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_awg_mc.sv
// ============================================================================
//  Module   : tb_awg_mc
//  Purpose  : Scoreboard bench for awg_mc, three channels with directed vectors.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_awg_mc;
    localparam int DW  = 12;
    localparam int AW  = 10;
    localparam int NCH = 3;
    localparam int PW  = 4;
    localparam int CW  = 2;

    logic                ck = 1'b0;
    logic                rst_n = 1'b0;
    logic [2*NCH-1:0]    ch_mode = '0;
    logic [PW*NCH-1:0]   ch_pre = '0;
    logic [AW*NCH-1:0]   ch_len = '0;
    logic [DW*NCH-1:0]   direct_in = '0;
    logic [NCH-1:0]      trig = '0;
    logic [DW*NCH-1:0]   dout;
    logic [NCH-1:0]      busy;
    logic [NCH-1:0]      done;

    awg_mc_if #(.DW(DW), .AW(AW), .CW(CW)) wif ();

    awg_mc #(.DW(DW), .AW(AW), .NCH(NCH), .PW(PW)) dut (
        .ck        (ck),
        .rst_n     (rst_n),
        .wr        (wif.slave),
        .ch_mode   (ch_mode),
        .ch_pre    (ch_pre),
        .ch_len    (ch_len),
        .direct_in (direct_in),
        .trig      (trig),
        .out       (dout),
        .busy      (busy),
        .done      (done)
    );

    always #5 ck = ~ck;

    int cyc = 0;
    always @(posedge ck) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int ch;
        int kind;
        int val;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic int actual(int ch, int kind);
        case (kind)
            0:       return int'(dout[ch*DW +: DW]);
            1:       return int'(busy[ch]);
            default: return int'(done[ch]);
        endcase
    endfunction

    function automatic string kname(int kind);
        return (kind == 0) ? "out" : (kind == 1) ? "busy" : "done";
    endfunction

    // Monitor: retires every expectation due in this cycle.
    int mon_act;
    always @(negedge ck) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                mon_act = actual(q[i].ch, q[i].kind);
                n_vec++;
                if (q[i].cyc < cyc || mon_act != q[i].val) begin
                    n_bad++;
                    $display("FAIL %s ch%0d cyc%0d: got 0x%0h, expected 0x%0h",
                             kname(q[i].kind), q[i].ch, q[i].cyc, mon_act, q[i].val);
                end
                q.delete(i);
            end
        end
    end

    task automatic tk(int n);
        repeat (n) @(posedge ck);
        #1;
    endtask

    task automatic expect_at(int at, int ch, int kind, int val);
        exp_t e;
        e.cyc = at; e.ch = ch; e.kind = kind; e.val = val;
        q.push_back(e);
    endtask

    task automatic set_mode(int ch, logic [1:0] m);
        ch_mode[2*ch +: 2] = m;
    endtask

    task automatic set_pre(int ch, logic [PW-1:0] p);
        ch_pre[PW*ch +: PW] = p;
    endtask

    task automatic set_len(int ch, logic [AW-1:0] l);
        ch_len[AW*ch +: AW] = l;
    endtask

    task automatic wr(int ch, int a, int d);
        wif.wr_en   = 1'b1;
        wif.wr_ch   = CW'(ch);
        wif.wr_addr = AW'(a);
        wif.wr_data = DW'(d);
        tk(1);
        wif.wr_en   = 1'b0;
    endtask

    initial begin
        int   k;
        exp_t e;
        wif.wr_en = 1'b0; wif.wr_ch = '0; wif.wr_addr = '0; wif.wr_data = '0;

        // Reset state
        tk(2);
        k = cyc;
        for (int c = 0; c < NCH; c++) begin
            expect_at(k, c, 0, 0); expect_at(k, c, 1, 0); expect_at(k, c, 2, 0);
        end
        tk(2);
        rst_n = 1'b1;
        tk(1);

        // Loop, prescaler 1, wrap with no gap
        for (int i = 0; i < 8; i++) wr(0, i, 'h100 + i);
        set_len(0, 7); set_pre(0, 1); set_mode(0, 2'b10);
        k = cyc; trig[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            expect_at(k + 2 + i, 0, 0, 'h100 + i % 8);
            expect_at(k + 2 + i, 0, 1, 1);
        end
        expect_at(k + 9, 0, 2, 0);
        tk(1); trig[0] = 1'b0; tk(12);

        // Prescaler 3
        set_mode(0, 2'b00); tk(1);
        set_pre(0, 3); set_mode(0, 2'b10);
        k = cyc; trig[0] = 1'b1;
        for (int i = 0; i < 24; i++) expect_at(k + 2 + i, 0, 0, 'h100 + (i / 3) % 8);
        tk(1); trig[0] = 1'b0; tk(26);

        // Prescaler 0 behaves as 1
        set_mode(0, 2'b00); tk(1);
        set_pre(0, 0); set_mode(0, 2'b10);
        k = cyc; trig[0] = 1'b1;
        for (int i = 0; i < 10; i++) expect_at(k + 2 + i, 0, 0, 'h100 + i % 8);
        tk(1); trig[0] = 1'b0; tk(12);

        // Lowering prescaler 15 -> 1 mid-count ticks on the next edge
        set_mode(0, 2'b00); tk(1);
        set_pre(0, 15); set_mode(0, 2'b10);
        k = cyc; trig[0] = 1'b1;
        tk(1); trig[0] = 1'b0; tk(1);
        set_pre(0, 1);
        expect_at(k + 2, 0, 0, 'h100);
        expect_at(k + 3, 0, 0, 'h100);
        expect_at(k + 4, 0, 0, 'h101);
        expect_at(k + 5, 0, 0, 'h102);
        tk(5);
        set_mode(0, 2'b00);

        // One-shot on ch1, played twice
        for (int i = 0; i < 4; i++) wr(1, i, 'hA00 + i);
        set_len(1, 3); set_pre(1, 2); set_mode(1, 2'b11);
        for (int rep = 0; rep < 2; rep++) begin
            k = cyc; trig[1] = 1'b1;
            for (int i = 0; i < 8; i++) begin
                expect_at(k + 2 + i, 1, 0, 'hA00 + i / 2);
                if (i < 7) expect_at(k + 2 + i, 1, 1, 1);
            end
            expect_at(k + 8,  1, 2, 0);
            expect_at(k + 9,  1, 2, 1);
            expect_at(k + 10, 1, 2, 0);
            expect_at(k + 9,  1, 1, 0);
            expect_at(k + 10, 1, 1, 0);
            expect_at(k + 10, 1, 0, 'hA03);
            expect_at(k + 12, 1, 0, 'hA03);
            tk(1); trig[1] = 1'b0; tk(14);
            n_vec++;
            if (dout[DW +: DW] !== 12'hA03 || busy[1] !== 1'b0) begin
                n_bad++;
                $display("FAIL one-shot rep%0d end: out1=0x%0h busy1=%0b", rep,
                         dout[DW +: DW], busy[1]);
            end
        end

        // Direct then hold; trig ignored in hold
        direct_in[0 +: DW] = 12'h0AE; set_mode(0, 2'b01);
        k = cyc;
        expect_at(k + 1, 0, 0, 'h0AE);
        tk(2);
        n_vec++;
        if (dout[0 +: DW] !== 12'h0AE) begin
            n_bad++;
            $display("FAIL direct: out0=0x%0h", dout[0 +: DW]);
        end
        set_mode(0, 2'b00); direct_in[0 +: DW] = 12'h123; trig[0] = 1'b1;
        k = cyc;
        expect_at(k + 2, 0, 0, 'h0AE);
        expect_at(k + 2, 0, 1, 0);
        expect_at(k + 3, 0, 0, 'h0AE);
        tk(1); trig[0] = 1'b0; tk(4);
        n_vec++;
        if (dout[0 +: DW] !== 12'h0AE || busy[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL hold: out0=0x%0h busy0=%0b", dout[0 +: DW], busy[0]);
        end

        // Async reset mid-loop, RAM retained afterwards
        set_pre(0, 1); set_len(0, 7); set_mode(0, 2'b10);
        trig[0] = 1'b1; tk(1); trig[0] = 1'b0; tk(4);
        rst_n = 1'b0;
        k = cyc;
        expect_at(k, 0, 0, 0); expect_at(k, 0, 1, 0); expect_at(k, 1, 0, 0);
        tk(2); rst_n = 1'b1; tk(1);
        k = cyc; trig[0] = 1'b1;
        for (int i = 0; i < 9; i++) expect_at(k + 2 + i, 0, 0, 'h100 + i % 8);
        tk(1); trig[0] = 1'b0; tk(10);

        // Both channels looping; live write to ch1 and an out-of-range write
        set_len(1, 3); set_pre(1, 1); set_mode(1, 2'b10);
        k = cyc; trig = 3'b011;
        for (int i = 0; i < 24; i++) begin
            expect_at(k + 2 + i, 0, 0, 'h100 + i % 8);
            expect_at(k + 2 + i, 1, 0, (i % 4 == 2 && i >= 6) ? 'hFFF : 'hA00 + i % 4);
        end
        tk(1); trig = '0; tk(2);
        wr(1, 2, 'hFFF);
        tk(4);
        wif.wr_en = 1'b1; wif.wr_ch = 2'd3; wif.wr_addr = 10'd1; wif.wr_data = 12'h555;
        tk(2);
        wif.wr_en = 1'b0;
        tk(16);
        n_vec++;
        if (busy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL busy0 after live writes: %0b", busy[0]);
        end

        tk(3);
        while (q.size() > 0) begin
            e = q.pop_front();
            n_vec++; n_bad++;
            $display("FAIL %s ch%0d cyc%0d: never checked, expected 0x%0h",
                     kname(e.kind), e.ch, e.cyc, e.val);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
